// File: rtl/map_fetch_sched_pkg.sv
// Shared widths and tile-type encodings for the map RAM fetch scheduler.
package map_fetch_sched_pkg;

  localparam int TILE_BITS = 5;
  localparam int MAP_BITS  = 4;
  localparam int TYPE_W    = 4;

  typedef enum logic [TYPE_W-1:0] {
    TILE_GROUND = 4'd0,
    TILE_FOOD   = 4'd1,
    TILE_BODY_H = 4'd2,
    TILE_BODY_V = 4'd3,
    TILE_HEAD   = 4'd4,
    TILE_WALL   = 4'd5
  } tile_type_e;

endpackage

// File: rtl/map_fetch_sched.sv
// Shares the single-port map RAM between one-tile-ahead display fetches,
// a column-0 prefetch in horizontal blanking, and game-logic writes.
//
// slot state  | meaning
// SLOT_IDLE   | RAM idle this cycle
// SLOT_FETCH  | reading the next tile of the current line
// SLOT_LINE   | reading column 0 of the next line
// SLOT_WRITE  | game write on the bus, wr_ack high
//
// tag state   | meaning
// TAG_NONE    | no read data arriving this cycle
// TAG_FETCH   | ram_rdata holds a tile fetch
// TAG_LINE    | ram_rdata holds a line prefetch
module map_fetch_sched
  import map_fetch_sched_pkg::*;
#(
  parameter int FETCH_SLOT = 24,
  parameter int V_ACTIVE   = 480
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [9:0]              pix_x,
  input  logic [9:0]              pix_y,
  input  logic                    pix_valid,
  input  logic                    wr_req,
  input  logic [MAP_BITS-1:0]     wr_x,
  input  logic [MAP_BITS-1:0]     wr_y,
  input  logic [TYPE_W-1:0]       wr_type,
  output logic                    wr_ack,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [2*MAP_BITS-1:0]   ram_addr,
  output logic [TYPE_W-1:0]       ram_wdata,
  input  logic [TYPE_W-1:0]       ram_rdata,
  output logic [TYPE_W-1:0]       tex_type,
  output logic [TILE_BITS-1:0]    tex_x,
  output logic [TILE_BITS-1:0]    tex_y,
  output logic                    tex_valid
);

  localparam logic [1:0] SLOT_IDLE  = 2'd0;
  localparam logic [1:0] SLOT_FETCH = 2'd1;
  localparam logic [1:0] SLOT_LINE  = 2'd2;
  localparam logic [1:0] SLOT_WRITE = 2'd3;

  localparam logic [1:0] TAG_NONE  = 2'd0;
  localparam logic [1:0] TAG_FETCH = 2'd1;
  localparam logic [1:0] TAG_LINE  = 2'd2;

  localparam logic [TILE_BITS-1:0] FETCH_X = FETCH_SLOT[TILE_BITS-1:0];
  localparam logic [9:0]           V_LIM   = V_ACTIVE[9:0];

  logic [1:0]              slot_d, slot_q, tag_q;
  logic [2*MAP_BITS-1:0]   addr_d;
  logic [MAP_BITS:0]       fetch_col;
  logic [9:0]              y_next;
  logic [MAP_BITS-1:0]     row_next;
  logic                    fetch_hit, pf_hit, wr_hit;
  logic                    pix_valid_q, line_pf_pend;
  logic [TYPE_W-1:0]       cur_type, next_type;

  // Column 16 does not exist, so the carry out of the +1 suppresses the fetch.
  assign fetch_col = {1'b0, pix_x[TILE_BITS+MAP_BITS-1:TILE_BITS]} + {{MAP_BITS{1'b0}}, 1'b1};
  assign fetch_hit = pix_valid && (pix_x[TILE_BITS-1:0] == FETCH_X) &&
                     !fetch_col[MAP_BITS] && !pix_x[TILE_BITS+MAP_BITS];

  assign y_next   = pix_y + 10'd1;
  assign row_next = (y_next >= V_LIM) ? '0 : y_next[TILE_BITS+MAP_BITS-1:TILE_BITS];
  assign pf_hit   = line_pf_pend && !pix_valid;
  assign wr_hit   = wr_req && !wr_ack;

  always_comb begin
    slot_d = SLOT_IDLE;
    addr_d = ram_addr;
    if (fetch_hit) begin
      slot_d = SLOT_FETCH;
      addr_d = {pix_y[TILE_BITS+MAP_BITS-1:TILE_BITS], fetch_col[MAP_BITS-1:0]};
    end else if (pf_hit) begin
      slot_d = SLOT_LINE;
      addr_d = {row_next, {MAP_BITS{1'b0}}};
    end else if (wr_hit) begin
      slot_d = SLOT_WRITE;
      addr_d = {wr_y, wr_x};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= SLOT_IDLE;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      wr_ack    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      slot_q   <= slot_d;
      ram_en   <= (slot_d != SLOT_IDLE);
      ram_we   <= (slot_d == SLOT_WRITE);
      wr_ack   <= (slot_d == SLOT_WRITE);
      ram_addr <= addr_d;
      if (slot_d == SLOT_WRITE) ram_wdata <= wr_type;
    end
  end

  // Tag trails the bus slot by one cycle, lining up with ram_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q     <= TAG_NONE;
      next_type <= '0;
    end else begin
      unique case (slot_q)
        SLOT_FETCH: tag_q <= TAG_FETCH;
        SLOT_LINE:  tag_q <= TAG_LINE;
        default:    tag_q <= TAG_NONE;
      endcase
      if (tag_q != TAG_NONE) next_type <= ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_q  <= 1'b0;
      line_pf_pend <= 1'b1;
    end else begin
      pix_valid_q <= pix_valid;
      if (slot_d == SLOT_LINE) line_pf_pend <= 1'b0;
      else if (pix_valid_q && !pix_valid) line_pf_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tex_valid <= 1'b0;
      tex_x     <= '0;
      tex_y     <= '0;
      tex_type  <= '0;
      cur_type  <= '0;
    end else begin
      tex_valid <= pix_valid;
      tex_x     <= pix_x[TILE_BITS-1:0];
      tex_y     <= pix_y[TILE_BITS-1:0];
      if (pix_valid) begin
        if (pix_x[TILE_BITS+MAP_BITS]) begin
          tex_type <= '0;
        end else if (pix_x[TILE_BITS-1:0] == '0) begin
          tex_type <= next_type;
          cur_type <= next_type;
        end else begin
          tex_type <= cur_type;
        end
      end
    end
  end

endmodule

// File: tb/tb_map_fetch_sched.sv
// Randomized bench for map_fetch_sched: a random tile map is scanned line by line
// and every texel is compared with the map contents as the game last wrote them.
module tb_map_fetch_sched;
  import map_fetch_sched_pkg::*;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic [9:0] pix_x     = '0;
  logic [9:0] pix_y     = '0;
  logic       pix_valid = 1'b0;
  logic       wr_req    = 1'b0;
  logic [3:0] wr_x      = '0;
  logic [3:0] wr_y      = '0;
  logic [3:0] wr_type   = '0;
  logic       wr_ack, ram_en, ram_we;
  logic [7:0] ram_addr;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata = '0;
  logic [3:0] tex_type;
  logic [4:0] tex_x, tex_y;
  logic       tex_valid;

  logic [3:0] mem     [0:255];
  logic [3:0] ref_map [0:15][0:15];
  logic [3:0] last_type = '0;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  map_fetch_sched dut (
    .clk(clk), .rst_n(rst_n),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_type(wr_type), .wr_ack(wr_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .tex_type(tex_type), .tex_x(tex_x), .tex_y(tex_y), .tex_valid(tex_valid)
  );

  // Synchronous single-port map RAM.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pf_addr(input int y);
    int ny;
    ny = (y + 1 >= 480) ? 0 : y + 1;
    return (ny / 32) * 16;
  endfunction

  // Apply one beam position, clock it, and check the texel stage.
  task automatic tick_pix(input logic v, input int x, input int y);
    pix_valid = v;
    pix_x     = x[9:0];
    pix_y     = y[9:0];
    @(posedge clk); #1;
    chk_val("tex_valid", 32'(tex_valid), 32'(v));
    chk_val("tex_x", 32'(tex_x), x % 32);
    chk_val("tex_y", 32'(tex_y), y % 32);
    if (v) last_type = (x >= 512) ? 4'(TILE_GROUND) : ref_map[y / 32][x / 32];
    chk_val("tex_type", 32'(tex_type), 32'(last_type));
  endtask

  task automatic scan_line(input int y, input int width, input bit inject);
    int ack_cnt = 0;
    int ack_x   = -1;
    bit pf_seen = 1'b0;
    for (int x = 0; x < width; x++) begin
      if (inject && x == 24) begin
        wr_x = 4'd3; wr_y = 4'd2; wr_type = 4'd5; wr_req = 1'b1;
      end
      if (inject && ack_x >= 0 && x == ack_x + 2) wr_req = 1'b0;
      tick_pix(1'b1, x, y);
      if (x >= 512) begin
        chk_val("ram_en_offmap", 32'(ram_en), 0);
      end else if (x % 32 == 24) begin
        if (x / 32 < 15) begin
          chk_val("fetch_rd", 32'(ram_en && !ram_we), 1);
          chk_val("fetch_addr", 32'(ram_addr), (y / 32) * 16 + x / 32 + 1);
        end else begin
          chk_val("col15_no_fetch", 32'(ram_en), 0);
        end
      end
      if (inject && wr_ack) begin
        ack_cnt++;
        ack_x = x;
        chk_val("defer_wr_addr", 32'(ram_addr), 32'h23);
        chk_val("defer_wr_we", 32'(ram_we), 1);
        chk_val("defer_wr_data", 32'(ram_wdata), 5);
      end
    end
    if (inject) begin
      wr_req = 1'b0;
      chk_val("defer_ack_count", ack_cnt, 1);
      chk_val("defer_ack_x", ack_x, 25);
      ref_map[2][3] = 4'd5;
    end
    for (int i = 0; i < 16; i++) begin
      tick_pix(1'b0, width + i, y);
      if (ram_en && !ram_we && ram_addr == 8'(pf_addr(y))) pf_seen = 1'b1;
    end
    chk_val("line_pf", 32'(pf_seen), 1);
  endtask

  task automatic do_write(input int y, input int wx, input int wy, input int wt);
    int lat = 0;
    wr_x = 4'(wx); wr_y = 4'(wy); wr_type = 4'(wt); wr_req = 1'b1;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      tick_pix(1'b0, 700, y);
      if (wr_ack) begin
        lat = i;
        chk_val("wr_addr", 32'(ram_addr), wy * 16 + wx);
        chk_val("wr_we", 32'(ram_we), 1);
        chk_val("wr_data", 32'(ram_wdata), wt);
      end
    end
    wr_req = 1'b0;
    chk_val("wr_latency", lat, 1);
    tick_pix(1'b0, 700, y);
    chk_val("wr_ack_drop", 32'(wr_ack), 0);
    ref_map[wy][wx] = 4'(wt);
  endtask

  task automatic burst_write40(input int y);
    int acks = 0;
    bit prev = 1'b0;
    wr_x = 4'd9; wr_y = 4'd7; wr_type = 4'($urandom_range(0, 5)); wr_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick_pix(1'b0, 700, y);
      chk_val("ack_consec", 32'(prev && wr_ack), 0);
      if (wr_ack) begin
        acks++;
        chk_val("burst_addr", 32'(ram_addr), 32'h79);
      end
      prev = wr_ack;
    end
    wr_req = 1'b0;
    tick_pix(1'b0, 700, y);
    chk_val("burst_acks", acks, 20);
    ref_map[7][9] = wr_type;
  endtask

  initial begin
    bit pf_seen;
    int w, wx, wy;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        ref_map[r][c]  = 4'($urandom_range(0, 5));
        mem[r * 16 + c] = ref_map[r][c];
      end
    for (int c = 0; c < 16; c++) begin
      ref_map[0][c] = 4'd0;
      mem[c]        = 4'd0;
    end
    ref_map[0][1] = 4'd1;
    mem[1]        = 4'd1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Put a write on the bus mid-line, then hit reset between clock edges.
    pix_valid = 1'b1; pix_x = 10'd37; pix_y = 10'd5;
    wr_x = 4'd4; wr_y = 4'd9; wr_type = ref_map[9][4]; wr_req = 1'b1;
    @(posedge clk); #1;
    chk_val("pre_rst_we", 32'(ram_we), 1);
    chk_val("pre_rst_ack", 32'(wr_ack), 1);
    chk_val("pre_rst_tex_valid", 32'(tex_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_val("rst_wr_ack", 32'(wr_ack), 0);
    chk_val("rst_ram_en", 32'(ram_en), 0);
    chk_val("rst_ram_we", 32'(ram_we), 0);
    chk_val("rst_ram_addr", 32'(ram_addr), 0);
    chk_val("rst_ram_wdata", 32'(ram_wdata), 0);
    chk_val("rst_tex_type", 32'(tex_type), 0);
    chk_val("rst_tex_x", 32'(tex_x), 0);
    chk_val("rst_tex_y", 32'(tex_y), 0);
    chk_val("rst_tex_valid", 32'(tex_valid), 0);
    wr_req = 1'b0; pix_valid = 1'b0; pix_x = 10'd656; pix_y = 10'd479;
    @(negedge clk);
    rst_n = 1'b1;
    last_type = '0;

    // Tail of vertical blanking: prefetch of row 0 must happen here.
    pf_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick_pix(1'b0, 656 + i, 479);
      if (ram_en && !ram_we && ram_addr == 8'h00) pf_seen = 1'b1;
    end
    chk_val("vblank_pf", 32'(pf_seen), 1);

    for (int y = 0; y < 480; y++) begin
      w = (y == 0 || y == 31 || y == 32 || y == 63 || y == 64 || y == 479 ||
           y % 50 == 7) ? 640 : 64;
      scan_line(y, w, y == 0);
      if (y == 100) begin
        burst_write40(y);
      end else if (y % 4 == 2) begin
        wx = $urandom_range(0, 15);
        wy = $urandom_range(0, 15);
        // Column 0 of the upcoming row is already latched for the next line.
        if (wx == 0 && wy == pf_addr(y) / 16) wx = 1;
        if (wx == 3 && wy == 2) wx = 4;
        do_write(y, wx, wy, $urandom_range(0, 5));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
